// File: rtl/logic_pod_pll_reconfig_sequencer.sv
// Retune sequencer for the ReconfigurablePLL dynamic reconfiguration port.
// Accepts one request, issues start / optional VCO / per-output / finish
// commands, waits for relock and reports a completion status.
//
// state      | meaning
// IDLE       | ready for a request
// WAIT_IDLE  | waiting for the PLL to drop busy
// START      | reconfig_start pulse
// WAIT_START | waiting for cmd_done after start
// VCO        | reconfig_vco_en pulse
// WAIT_VCO   | waiting for cmd_done after VCO write
// NEXT_OUT   | pick lowest remaining output, or finish
// OUT        | reconfig_output_en pulse for one output
// WAIT_OUT   | waiting for cmd_done after output write
// FINISH     | reconfig_finish pulse (also used to release after a stall)
// WAIT_LOCK  | waiting for !busy && locked
// DONE       | done pulse, status updated
module logic_pod_pll_reconfig_sequencer #(
  parameter int unsigned CMD_TIMEOUT  = 1023,
  parameter int unsigned LOCK_TIMEOUT = 65535
) (
  input  logic       clk_125mhz,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_vco_en,
  input  logic [6:0] req_vco_mult,
  input  logic [6:0] req_vco_indiv,
  input  logic       req_vco_bandwidth,
  input  logic [5:0] req_output_mask,
  input  logic [7:0] req_output_div,
  input  logic [8:0] req_output_phase,
  input  logic       busy,
  input  logic       locked,
  input  logic       reconfig_cmd_done,
  output logic       reconfig_start,
  output logic       reconfig_finish,
  output logic       reconfig_vco_en,
  output logic       reconfig_output_en,
  output logic [6:0] reconfig_vco_mult,
  output logic [6:0] reconfig_vco_indiv,
  output logic       reconfig_vco_bandwidth,
  output logic [2:0] reconfig_output_idx,
  output logic [7:0] reconfig_output_div,
  output logic [8:0] reconfig_output_phase,
  output logic       done,
  output logic [1:0] status
);

  localparam int unsigned CW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CW-1:0] CMD_LIMIT  = CW'(CMD_TIMEOUT);
  localparam logic [CW-1:0] LOCK_LIMIT = CW'(LOCK_TIMEOUT);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_IDLE, S_START, S_WAIT_START, S_VCO, S_WAIT_VCO,
    S_NEXT_OUT, S_OUT, S_WAIT_OUT, S_FINISH, S_WAIT_LOCK, S_DONE
  } state_t;

  state_t          state, next_state;
  logic            vco_en_q;
  logic [5:0]      work_mask;
  logic [2:0]      low_idx;
  logic [1:0]      err_q, err_d;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   limit;
  logic            tmo;
  logic            in_wait;
  logic            accept;

  assign accept  = req_valid && req_ready;
  assign in_wait = (state == S_WAIT_IDLE) || (state == S_WAIT_START) ||
                   (state == S_WAIT_VCO)  || (state == S_WAIT_OUT)   ||
                   (state == S_WAIT_LOCK);
  assign limit   = (state == S_WAIT_LOCK) ? LOCK_LIMIT : CMD_LIMIT;

  // Lowest set bit of the remaining output mask (scan high to low so low wins).
  always_comb begin
    low_idx = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (work_mask[i]) low_idx = 3'(i);
    end
  end

  // State register.
  always_ff @(posedge clk_125mhz) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state decode plus the error code that will be reported at DONE.
  always_comb begin
    next_state = state;
    err_d      = err_q;
    case (state)
      S_IDLE: begin
        if (accept) begin
          next_state = S_WAIT_IDLE;
          err_d      = 2'b00;
        end
      end
      S_WAIT_IDLE: begin
        if (!busy) next_state = S_START;
        else if (tmo) begin
          next_state = S_DONE;
          err_d      = 2'b01;
        end
      end
      S_START: next_state = S_WAIT_START;
      S_WAIT_START: begin
        if (reconfig_cmd_done) next_state = vco_en_q ? S_VCO : S_NEXT_OUT;
        else if (tmo) begin
          next_state = S_FINISH;
          err_d      = 2'b10;
        end
      end
      S_VCO: next_state = S_WAIT_VCO;
      S_WAIT_VCO, S_WAIT_OUT: begin
        if (reconfig_cmd_done) next_state = S_NEXT_OUT;
        else if (tmo) begin
          next_state = S_FINISH;
          err_d      = 2'b10;
        end
      end
      S_NEXT_OUT: next_state = (work_mask != 6'd0) ? S_OUT : S_FINISH;
      S_OUT:      next_state = S_WAIT_OUT;
      S_FINISH:   next_state = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (!busy && locked) next_state = S_DONE;
        else if (tmo) begin
          next_state = S_DONE;
          // A stalled command already forced the finish; keep that cause.
          if (err_q == 2'b00) err_d = 2'b11;
        end
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Shared wait timer: cleared outside/on entry to a wait state, saturating;
  // tmo is registered one cycle after the count reaches its limit.
  always_ff @(posedge clk_125mhz) begin
    if (reset || !in_wait || (next_state != state)) begin
      cnt <= '0;
      tmo <= 1'b0;
    end else begin
      if (cnt != limit) cnt <= cnt + CW'(1);
      tmo <= (cnt == limit);
    end
  end

  // Registered outputs and request capture; pulses decode the upcoming state.
  always_ff @(posedge clk_125mhz) begin
    if (reset) begin
      req_ready              <= 1'b0;
      reconfig_start         <= 1'b0;
      reconfig_finish        <= 1'b0;
      reconfig_vco_en        <= 1'b0;
      reconfig_output_en     <= 1'b0;
      reconfig_vco_mult      <= 7'd0;
      reconfig_vco_indiv     <= 7'd0;
      reconfig_vco_bandwidth <= 1'b0;
      reconfig_output_idx    <= 3'd0;
      reconfig_output_div    <= 8'd0;
      reconfig_output_phase  <= 9'd0;
      done                   <= 1'b0;
      status                 <= 2'b00;
      vco_en_q               <= 1'b0;
      work_mask              <= 6'd0;
      err_q                  <= 2'b00;
    end else begin
      err_q              <= err_d;
      req_ready          <= (next_state == S_IDLE);
      reconfig_start     <= (next_state == S_START);
      reconfig_finish    <= (next_state == S_FINISH);
      reconfig_vco_en    <= (next_state == S_VCO);
      reconfig_output_en <= (next_state == S_OUT);
      done               <= (next_state == S_DONE);
      if (next_state == S_DONE) status <= err_d;
      if ((state == S_IDLE) && accept) begin
        vco_en_q               <= req_vco_en;
        work_mask              <= req_output_mask;
        reconfig_vco_mult      <= req_vco_mult;
        reconfig_vco_indiv     <= req_vco_indiv;
        reconfig_vco_bandwidth <= req_vco_bandwidth;
        reconfig_output_div    <= req_output_div;
        reconfig_output_phase  <= req_output_phase;
      end
      if (next_state == S_OUT) begin
        reconfig_output_idx <= low_idx;
        work_mask           <= work_mask & ~(6'b000001 << low_idx);
      end
    end
  end

endmodule

// File: tb/tb_logic_pod_pll_reconfig_sequencer.sv
// Directed bench for the PLL reconfig sequencer with a small PLL responder.
module tb_logic_pod_pll_reconfig_sequencer;

  logic       clk_125mhz = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_vco_en = 1'b0;
  logic [6:0] req_vco_mult = '0;
  logic [6:0] req_vco_indiv = '0;
  logic       req_vco_bandwidth = 1'b0;
  logic [5:0] req_output_mask = '0;
  logic [7:0] req_output_div = '0;
  logic [8:0] req_output_phase = '0;
  logic       busy, locked;
  logic       reconfig_cmd_done;
  logic       reconfig_start, reconfig_finish, reconfig_vco_en, reconfig_output_en;
  logic [6:0] reconfig_vco_mult, reconfig_vco_indiv;
  logic       reconfig_vco_bandwidth;
  logic [2:0] reconfig_output_idx;
  logic [7:0] reconfig_output_div;
  logic [8:0] reconfig_output_phase;
  logic       done;
  logic [1:0] status;

  logic_pod_pll_reconfig_sequencer #(.CMD_TIMEOUT(15), .LOCK_TIMEOUT(100)) dut (
    .clk_125mhz(clk_125mhz), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_vco_en(req_vco_en), .req_vco_mult(req_vco_mult), .req_vco_indiv(req_vco_indiv),
    .req_vco_bandwidth(req_vco_bandwidth), .req_output_mask(req_output_mask),
    .req_output_div(req_output_div), .req_output_phase(req_output_phase),
    .busy(busy), .locked(locked), .reconfig_cmd_done(reconfig_cmd_done),
    .reconfig_start(reconfig_start), .reconfig_finish(reconfig_finish),
    .reconfig_vco_en(reconfig_vco_en), .reconfig_output_en(reconfig_output_en),
    .reconfig_vco_mult(reconfig_vco_mult), .reconfig_vco_indiv(reconfig_vco_indiv),
    .reconfig_vco_bandwidth(reconfig_vco_bandwidth), .reconfig_output_idx(reconfig_output_idx),
    .reconfig_output_div(reconfig_output_div), .reconfig_output_phase(reconfig_output_phase),
    .done(done), .status(status)
  );

  always #4 clk_125mhz = ~clk_125mhz;

  // PLL model modes: 0 ideal, 1 busy stuck, 2 output commands never answered, 3 never locks
  int pll_mode = 0;
  assign busy   = (pll_mode == 1);
  assign locked = (pll_mode != 3);

  always @(posedge clk_125mhz) begin
    if (reset) reconfig_cmd_done <= 1'b0;
    else reconfig_cmd_done <= reconfig_start || reconfig_vco_en ||
                              (reconfig_output_en && (pll_mode != 2));
  end

  int cyc = 0;
  always @(posedge clk_125mhz) cyc <= cyc + 1;

  typedef struct {
    int          mode;
    logic        vco_en;
    logic [6:0]  mult;
    logic [6:0]  indiv;
    logic        bw;
    logic [5:0]  mask;
    logic [7:0]  div;
    logic [8:0]  phase;
    logic [31:0] exp_seq;     // one nibble per pulse: 1 start, 2 vco, 3 finish, 8+n output n
    logic [1:0]  exp_status;
    int          exp_lat;     // posedges from acceptance to done
  } vec_t;

  vec_t vecs [8];

  int compared = 0;
  int mismatched = 0;

  // Pulse monitor, sampled on the falling edge.
  logic        log_en = 1'b0;
  logic [31:0] seq;
  int          multi_err, data_err;
  logic        done_seen;
  int          done_cyc;
  logic [1:0]  done_status;
  logic [7:0]  cur_div;
  logic [8:0]  cur_phase;
  logic [6:0]  cur_mult, cur_indiv;
  logic        cur_bw;

  always @(negedge clk_125mhz) begin
    if (log_en) begin
      if ($countones({reconfig_start, reconfig_finish, reconfig_vco_en, reconfig_output_en}) > 1)
        multi_err++;
      if (reconfig_start)  seq = (seq << 4) | 32'h1;
      if (reconfig_vco_en) begin
        seq = (seq << 4) | 32'h2;
        if ({reconfig_vco_mult, reconfig_vco_indiv, reconfig_vco_bandwidth} !== {cur_mult, cur_indiv, cur_bw})
          data_err++;
      end
      if (reconfig_output_en) begin
        seq = (seq << 4) | {28'd0, 1'b1, reconfig_output_idx};
        if ({reconfig_output_div, reconfig_output_phase} !== {cur_div, cur_phase}) data_err++;
      end
      if (reconfig_finish) seq = (seq << 4) | 32'h3;
      if (done && !done_seen) begin
        done_seen   = 1'b1;
        done_cyc    = cyc;
        done_status = status;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outputs();
    return {21'd0, req_ready, reconfig_start, reconfig_finish, reconfig_vco_en, reconfig_output_en,
            reconfig_vco_mult, reconfig_vco_indiv, reconfig_vco_bandwidth, reconfig_output_idx,
            reconfig_output_div, reconfig_output_phase, done, status};
  endfunction

  // Present one request, returns the cycle stamp of the acceptance edge.
  task automatic accept_req(input vec_t v, output int acc);
    int g;
    pll_mode  = v.mode;
    cur_div   = v.div;  cur_phase = v.phase;
    cur_mult  = v.mult; cur_indiv = v.indiv; cur_bw = v.bw;
    seq = 0; multi_err = 0; data_err = 0; done_seen = 1'b0;
    @(negedge clk_125mhz);
    g = 0;
    while (!req_ready && g < 20) begin
      @(negedge clk_125mhz);
      g++;
    end
    req_vco_en = v.vco_en; req_vco_mult = v.mult; req_vco_indiv = v.indiv;
    req_vco_bandwidth = v.bw; req_output_mask = v.mask;
    req_output_div = v.div; req_output_phase = v.phase;
    req_valid = 1'b1;
    log_en = 1'b1;
    @(posedge clk_125mhz);
    #1;
    acc = cyc;
    req_valid = 1'b0;
    // Request fields must be ignored once the sequence is running.
    req_vco_en = ~v.vco_en; req_vco_mult = 7'($urandom); req_vco_indiv = 7'($urandom);
    req_vco_bandwidth = ~v.bw; req_output_mask = 6'($urandom);
    req_output_div = ~v.div; req_output_phase = ~v.phase;
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int acc, g;
    accept_req(v, acc);
    g = 0;
    while (!done_seen && g < 400) begin
      @(negedge clk_125mhz);
      g++;
    end
    log_en = 1'b0;
    chk($sformatf("v%0d done_seen", n), done_seen, 1);
    chk($sformatf("v%0d pulse_order", n), seq, v.exp_seq);
    chk($sformatf("v%0d status", n), done_status, v.exp_status);
    chk($sformatf("v%0d latency", n), done_cyc - acc, v.exp_lat);
    chk($sformatf("v%0d one_pulse_per_cycle", n), multi_err, 0);
    chk($sformatf("v%0d data_at_pulse", n), data_err, 0);
    chk($sformatf("v%0d held_data", n),
        {reconfig_vco_mult, reconfig_vco_indiv, reconfig_vco_bandwidth, reconfig_output_div, reconfig_output_phase},
        {v.mult, v.indiv, v.bw, v.div, v.phase});
    @(negedge clk_125mhz);
    chk($sformatf("v%0d status_held", n), {done, status}, {1'b0, v.exp_status});
  endtask

  initial begin
    int acc, g;
    //          mode vco  mult    indiv   bw    mask        div     phase    seq         st     lat
    vecs[0] = '{0, 1'b0, 7'd0,   7'd0,   1'b0, 6'b000001, 8'd5,   9'd90,  32'h183,    2'd0,  9};
    vecs[1] = '{0, 1'b1, 7'd10,  7'd1,   1'b1, 6'b101010, 8'd17,  9'd300, 32'h129BD3, 2'd0,  17};
    vecs[2] = '{0, 1'b0, 7'd3,   7'd4,   1'b0, 6'b000000, 8'd3,   9'd1,   32'h13,     2'd0,  6};
    vecs[3] = '{0, 1'b1, 7'd127, 7'd127, 1'b0, 6'b100000, 8'd255, 9'd511, 32'h12D3,   2'd0,  11};
    vecs[4] = '{1, 1'b0, 7'd9,   7'd2,   1'b1, 6'b000001, 8'd7,   9'd45,  32'h0,      2'd1,  17};
    vecs[5] = '{2, 1'b0, 7'd0,   7'd0,   1'b0, 6'b000011, 8'd8,   9'd180, 32'h183,    2'd2,  24};
    vecs[6] = '{3, 1'b0, 7'd0,   7'd0,   1'b0, 6'b000001, 8'd2,   9'd10,  32'h183,    2'd3,  110};
    vecs[7] = '{0, 1'b0, 7'd0,   7'd0,   1'b0, 6'b010000, 8'd6,   9'd270, 32'h1C3,    2'd0,  9};

    // Reset values and release timing of req_ready.
    repeat (3) @(negedge clk_125mhz);
    chk("reset_outputs", all_outputs(), 64'd0);
    reset = 1'b0;
    chk("ready_before_edge", req_ready, 0);
    @(negedge clk_125mhz);
    chk("ready_after_release", req_ready, 1);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Reset while waiting for an output command that is never answered.
    accept_req(vecs[5], acc);
    g = 0;
    while (!reconfig_output_en && g < 50) begin
      @(negedge clk_125mhz);
      g++;
    end
    chk("midrst_out_pulse_seen", reconfig_output_en, 1);
    repeat (3) @(negedge clk_125mhz);
    reset = 1'b1;
    @(negedge clk_125mhz);
    chk("midrst_outputs_zero", all_outputs(), 64'd0);
    log_en = 1'b0;
    chk("midrst_no_finish", seq, 32'h18);
    reset = 1'b0;
    chk("midrst_ready_low", req_ready, 0);
    @(negedge clk_125mhz);
    chk("midrst_ready_back", req_ready, 1);
    run_vec(vecs[0], 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
